// File: rtl/io_datamem.sv
// Data memory for the single-cycle CPU: word-addressed RAM plus an I/O page at 0xffffff00
// holding HEX/LED registers, synchronised switches, debounced keys with press flags and a cycle counter.
module io_datamem #(
    parameter int RAM_AW     = 5,
    parameter int NUM_SW     = 10,
    parameter int NUM_KEY    = 4,
    parameter int NUM_HEX    = 6,
    parameter int NUM_LED    = 10,
    parameter int DEB_CYCLES = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          addr,
    input  logic [31:0]          datain,
    input  logic                 we,
    output logic [31:0]          dataout,
    input  logic [NUM_SW-1:0]    sw,
    input  logic [NUM_KEY-1:0]   key,
    output logic [7*NUM_HEX-1:0] hex,
    output logic [NUM_LED-1:0]   led
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES - 1);

    localparam logic [7:0] OFF_SW    = 8'h00;
    localparam logic [7:0] OFF_KEY   = 8'h10;
    localparam logic [7:0] OFF_KEYEV = 8'h14;
    localparam logic [7:0] OFF_HEX0  = 8'h20;
    localparam logic [7:0] OFF_LED   = 8'h80;
    localparam logic [7:0] OFF_CYCLE = 8'h90;

    logic                is_io;
    logic [7:0]          off;
    logic                io_we;
    logic                ram_we;
    logic [RAM_AW-1:0]   widx;
    logic [NUM_HEX-1:0]  hex_hit;

    assign is_io  = (addr[31:8] == 24'hffffff);
    assign off    = addr[7:0];
    assign io_we  = we & is_io;
    assign ram_we = we & ~is_io & ~reset;
    assign widx   = addr[RAM_AW+1:2];

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        hex_hit = '0;
        for (int i = 0; i < NUM_HEX; i++)
            hex_hit[i] = (off == OFF_HEX0 + 8'(16 * i));
    end

    // ---------------- RAM ----------------
    logic [31:0] ram [2**RAM_AW];

    // NOTE: the RAM array has no reset branch; clearing it would turn block RAM into a flop array.
    always_ff @(posedge clock) begin
        if (ram_we)
            ram[widx] <= datain;
    end

    // ---------------- input synchronisers ----------------
    logic [NUM_SW-1:0]  sw_meta,  sw_sync;
    logic [NUM_KEY-1:0] key_meta, key_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            key_meta <= '1;
            key_sync <= '1;
        end else begin
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            key_meta <= key;
            key_sync <= key_meta;
        end
    end

    // ---------------- key debounce and press flags ----------------
    logic [NUM_KEY-1:0] pressed;
    logic [NUM_KEY-1:0] key_state;
    logic [NUM_KEY-1:0] key_rise;
    logic [NUM_KEY-1:0] key_ev;
    logic [NUM_KEY-1:0] ev_clr;
    logic [CW-1:0]      deb_cnt [NUM_KEY];

    assign pressed = ~key_sync;
    assign ev_clr  = (io_we && off == OFF_KEYEV) ? datain[NUM_KEY-1:0] : '0;

    always_comb begin
        key_rise = '0;
        for (int i = 0; i < NUM_KEY; i++)
            key_rise[i] = pressed[i] & ~key_state[i] & (deb_cnt[i] == DEB_MAX);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            key_state <= '0;
            key_ev    <= '0;
            for (int i = 0; i < NUM_KEY; i++)
                deb_cnt[i] <= '0;
        end else begin
            // A rising debounced edge beats a same-cycle W1C clear.
            key_ev <= (key_ev & ~ev_clr) | key_rise;
            for (int i = 0; i < NUM_KEY; i++) begin
                if (pressed[i] == key_state[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_MAX) begin
                    key_state[i] <= pressed[i];
                    deb_cnt[i]   <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CW'(1);
                end
            end
        end
    end

    // ---------------- output registers and cycle counter ----------------
    logic [6:0]         hex_reg [NUM_HEX];
    logic [NUM_LED-1:0] led_reg;
    logic [31:0]        cycle_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            led_reg   <= '0;
            cycle_cnt <= '0;
            for (int i = 0; i < NUM_HEX; i++)
                hex_reg[i] <= 7'h7f;
        end else begin
            cycle_cnt <= (io_we && off == OFF_CYCLE) ? 32'd0 : cycle_cnt + 32'd1;
            if (io_we && off == OFF_LED)
                led_reg <= datain[NUM_LED-1:0];
            for (int i = 0; i < NUM_HEX; i++)
                if (io_we && hex_hit[i])
                    hex_reg[i] <= datain[6:0];
        end
    end

    always_comb begin
        hex = '1;
        for (int i = 0; i < NUM_HEX; i++)
            hex[7*i +: 7] = hex_reg[i];
    end

    assign led = led_reg;

    // ---------------- read mux ----------------
    always_comb begin
        dataout = '0;
        if (is_io) begin
            case (off)
                OFF_SW:    dataout = 32'(sw_sync);
                OFF_KEY:   dataout = 32'(key_state);
                OFF_KEYEV: dataout = 32'(key_ev);
                OFF_LED:   dataout = 32'(led_reg);
                OFF_CYCLE: dataout = cycle_cnt;
                default:   dataout = '0;
            endcase
            for (int i = 0; i < NUM_HEX; i++)
                if (hex_hit[i])
                    dataout = 32'(hex_reg[i]);
        end else begin
            dataout = ram[widx];
        end
    end

endmodule

// File: tb/tb_io_datamem.sv
// Self-checking bench for io_datamem: directed vector table, multi-cycle key/cycle/reset
// sequences, then random RAM/I/O traffic against an array-based reference model.
module tb_io_datamem;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        we;
    logic [31:0] dataout;
    logic [9:0]  sw;
    logic [3:0]  key;
    logic [41:0] hex;
    logic [9:0]  led;

    io_datamem dut (
        .clock   (clock),
        .reset   (reset),
        .addr    (addr),
        .datain  (datain),
        .we      (we),
        .dataout (dataout),
        .sw      (sw),
        .key     (key),
        .hex     (hex),
        .led     (led)
    );

    always #5 clock = ~clock;

    int unsigned edges = 0;
    always @(posedge clock) edges++;

    int n_cmp  = 0;
    int n_fail = 0;
    int unsigned load_edge;

    localparam logic [31:0] A_SW    = 32'hffffff00;
    localparam logic [31:0] A_KEY   = 32'hffffff10;
    localparam logic [31:0] A_KEYEV = 32'hffffff14;
    localparam logic [31:0] A_HEX0  = 32'hffffff20;
    localparam logic [31:0] A_LED   = 32'hffffff80;
    localparam logic [31:0] A_CYCLE = 32'hffffff90;

    typedef struct {
        logic        do_wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    // Reference model for the random phase
    logic [31:0] m_ram   [32];
    bit          m_valid [32];
    logic [9:0]  m_led;
    logic [6:0]  m_hex   [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr   = a;
        datain = d;
        we     = 1'b1;
        tick();
        we     = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        we   = 1'b0;
        #1;
        check(name, dataout, exp);
    endtask

    initial begin
        logic [31:0] a, d;
        int          idx;

        reset = 1'b1; we = 1'b0; addr = '0; datain = '0; sw = '0; key = '1;
        repeat (3) tick();
        reset = 1'b0;
        load_edge = edges;

        // ---- reset state ----
        check("rst_hex_port", 32'(hex), 32'(42'h3ff_ffff_ffff));
        check("rst_led_port", 32'(led), 32'h0);
        rd_check("rst_hex0",  A_HEX0,  32'h7f);
        rd_check("rst_led",   A_LED,   32'h0);
        rd_check("rst_keyev", A_KEYEV, 32'h0);
        rd_check("rst_key",   A_KEY,   32'h0);
        rd_check("rst_cycle", A_CYCLE, 32'(edges - load_edge));

        // ---- directed vector table ----
        vecs[0]  = '{1'b1, A_LED,         32'h12345678, A_LED,         32'h278};
        vecs[1]  = '{1'b1, A_LED,         32'h000003ff, A_LED,         32'h3ff};
        vecs[2]  = '{1'b1, 32'hffffff70,  32'h00000040, 32'hffffff70,  32'h40};
        vecs[3]  = '{1'b1, A_HEX0,        32'hffffffa5, A_HEX0,        32'h25};
        vecs[4]  = '{1'b1, 32'hffffff84,  32'hdeadbeef, 32'hffffff84,  32'h0};
        vecs[5]  = '{1'b1, 32'hffffff24,  32'h00000011, 32'hffffff24,  32'h0};
        vecs[6]  = '{1'b0, 32'h0,         32'h0,        A_SW,          32'h0};
        vecs[7]  = '{1'b1, 32'h00000004,  32'h12345678, 32'h00000004,  32'h12345678};
        vecs[8]  = '{1'b1, 32'hffffff04,  32'hcafef00d, 32'h00000004,  32'h12345678};
        vecs[9]  = '{1'b1, 32'h00000084,  32'ha5a5a5a5, 32'h00000004,  32'ha5a5a5a5};
        vecs[10] = '{1'b1, A_KEY,         32'hffffffff, A_KEY,         32'h0};
        vecs[11] = '{1'b1, 32'hfffffe7c,  32'h0badcafe, 32'h0000007c,  32'h0badcafe};
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].do_wr) wr(vecs[i].waddr, vecs[i].wdata);
            rd_check($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
        end
        check("led_port",  32'(led),        32'h3ff);
        check("hex5_port", 32'(hex[41:35]), 32'h40);
        check("hex0_port", 32'(hex[6:0]),   32'h25);
        check("hex1_port", 32'(hex[13:7]),  32'h7f);

        // ---- switch latency ----
        sw = 10'h155;
        tick();
        rd_check("sw_1edge", A_SW, 32'h0);
        tick();
        rd_check("sw_2edge", A_SW, 32'h155);

        // ---- clean press on key[1] ----
        key = 4'b1101;
        repeat (17) tick();
        rd_check("key1_17edge",   A_KEY,   32'h0);
        rd_check("keyev1_17edge", A_KEYEV, 32'h0);
        tick();
        rd_check("key1_18edge",   A_KEY,   32'h2);
        rd_check("keyev1_18edge", A_KEYEV, 32'h2);
        key = 4'b1111;
        repeat (20) tick();
        rd_check("key1_release", A_KEY,   32'h0);
        rd_check("keyev1_stick", A_KEYEV, 32'h2);
        wr(A_KEYEV, 32'h2);
        rd_check("keyev1_w1c", A_KEYEV, 32'h0);

        // ---- bouncing key[0] never registers ----
        for (int k = 0; k < 20; k++) begin
            key[0] = ~key[0];
            repeat (5) tick();
            rd_check($sformatf("bounce_key%0d", k),   A_KEY,   32'h0);
            rd_check($sformatf("bounce_keyev%0d", k), A_KEYEV, 32'h0);
        end
        repeat (20) tick();

        // ---- W1C on the exact set cycle: set wins ----
        key[0] = 1'b0;
        repeat (17) tick();
        wr(A_KEYEV, 32'h1);
        rd_check("w1c_set_wins", A_KEYEV, 32'h1);
        rd_check("w1c_key0",     A_KEY,   32'h1);
        key[0] = 1'b1;
        repeat (20) tick();
        wr(A_KEYEV, 32'h1);
        rd_check("w1c_clear", A_KEYEV, 32'h0);

        // ---- cycle counter ----
        wr(A_CYCLE, 32'hdeadbeef);
        load_edge = edges;
        rd_check("cycle_load", A_CYCLE, 32'h0);
        repeat (10) tick();
        rd_check("cycle_10", A_CYCLE, 32'd10);
        dut.cycle_cnt = 32'hffff_fffe;
        tick();
        rd_check("cycle_max", A_CYCLE, 32'hffffffff);
        tick();
        rd_check("cycle_wrap", A_CYCLE, 32'h0);
        load_edge = edges;

        // ---- reset beats a same-cycle write ----
        wr(A_LED, 32'h3ff);
        check("led_pre_rst", 32'(led), 32'h3ff);
        addr = A_LED; datain = 32'h3ff; we = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; we = 1'b0;
        load_edge = edges;
        check("rst_wr_led", 32'(led), 32'h0);
        check("rst_wr_hex", 32'(hex[41:35]), 32'h7f);
        rd_check("rst_wr_cycle", A_CYCLE, 32'h0);

        // ---- randomised traffic vs reference model ----
        m_led = '0;
        for (int i = 0; i < 6; i++) m_hex[i] = 7'h7f;
        for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
        for (int it = 0; it < 300; it++) begin
            idx = $urandom_range(0, 31);
            a   = ($urandom & 32'h7fffff80) | (32'(idx) << 2) | ($urandom & 32'h3);
            d   = $urandom;
            case ($urandom_range(0, 5))
                0: begin
                    wr(a, d);
                    m_ram[idx]   = d;
                    m_valid[idx] = 1'b1;
                end
                1: if (m_valid[idx]) rd_check("rnd_ram", a, m_ram[idx]);
                2: begin
                    wr(A_LED, d);
                    m_led = d[9:0];
                end
                3: begin
                    idx = $urandom_range(0, 5);
                    wr(A_HEX0 + 32'(16 * idx), d);
                    m_hex[idx] = d[6:0];
                end
                4: begin
                    idx = $urandom_range(0, 5);
                    rd_check("rnd_hex", A_HEX0 + 32'(16 * idx), 32'(m_hex[idx]));
                    check("rnd_hex_port", 32'(hex[7*idx +: 7]), 32'(m_hex[idx]));
                    rd_check("rnd_led", A_LED, 32'(m_led));
                    check("rnd_led_port", 32'(led), 32'(m_led));
                end
                default: rd_check("rnd_cycle", A_CYCLE, 32'(edges - load_edge));
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/io_datamem.md
# io_datamem

Parametrised single-clock data memory with memory-mapped board I/O for the single-cycle CPU, replacing the fixed-width switch/key/HEX/LED data memory. It holds a word-addressed data RAM and an I/O page at the top of the address space. The I/O page adds registered, reset-defined display/LED outputs, synchronised switches, debounced keys with sticky press flags, and a free-running cycle counter. It sits on the CPU's data-memory port: address, write data and write enable in, read data out.

## Interface
- RAM_AW, 5, RAM word-address bits; RAM depth is 2^RAM_AW words of 32 bits.
- NUM_SW, 10, switch inputs (1..32).
- NUM_KEY, 4, push-button inputs (1..32); active-low at the pins.
- NUM_HEX, 6, seven-segment digits (1..6).
- NUM_LED, 10, LED outputs (1..32).
- DEB_CYCLES, 16, debounce stability count in clock cycles (>=2).
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  byte address from the CPU.
- datain  in  32  write data.
- we  in  1  write enable.
- dataout  out  32  read data, combinational from addr.
- sw  in  NUM_SW  raw switch levels (asynchronous).
- key  in  NUM_KEY  raw key levels, 0 = pressed (asynchronous).
- hex  out  7*NUM_HEX  digit i on bits [7i+6:7i], active-low segments.
- led  out  NUM_LED  LED drive, 1 = on.

## Operation
- I/O page: addr[31:8] == 24'hffffff. All other addresses go to the RAM, word index addr[RAM_AW+1:2]. Higher address bits alias.
- RAM: written on the rising edge when we=1 and the address is not I/O. Read is asynchronous. Contents are not reset.
- I/O map (offset = addr[7:0]):
  - 0x00 SW, R: synchronised switches, zero-extended.
  - 0x10 KEY, R: debounced pressed state (1 = pressed), zero-extended.
  - 0x14 KEYEV, R/W1C: sticky press flags. Writing 1 to a bit clears that bit.
  - 0x20+0x10*i HEXi, R/W for i < NUM_HEX: datain[6:0].
  - 0x80 LED, R/W: datain[NUM_LED-1:0].
  - 0x90 CYCLE, R/W: 32-bit free-running counter. Any write loads 0.
- Unmapped I/O offsets: reads return 0; writes are ignored. Offsets for HEXi with i >= NUM_HEX are unmapped.
- Synchronisers: every sw and key bit passes through 2 flip-flops before any use.
- Debounce, per key, on the inverted synchronised level p:
  - A counter resets to 0 whenever p equals the debounced state d.
  - Otherwise the counter increments. On reaching DEB_CYCLES-1 it sets d <= p and clears.
- Press flag: set on a d transition 0->1. If set and W1C clear hit the same bit in the same cycle, the flag is set (set wins).
- CYCLE: increments by 1 every cycle and wraps from 0xffffffff to 0. A write in the same cycle loads 0 (no increment that cycle).
- Reset values:
  - hex = all ones (segments off); led = 0.
  - KEYEV = 0; debounced state = 0; debounce counters = 0.
  - synchronisers = 0 for sw; synchronisers = 1 (released) for key.
  - CYCLE = 0.
  - dataout follows addr and register state. It is undefined only for never-written RAM words.
- Reset has priority over any write in the same cycle.

## Timing
- Writes: take effect at the rising edge where we=1. dataout reflects the new value in the following cycle.
- Reads: combinational, same cycle as addr, from register/RAM state.
- Switch latency: a change on sw is visible at SW after 2 rising edges.
- Key latency: a clean press is visible in KEY and KEYEV after 2 + DEB_CYCLES rising edges.
- Debounce boundary: bounces shorter than DEB_CYCLES stable cycles never change d and never set flags.
- A reset asserted mid-debounce discards the count. A key held through reset is reported as a new press after deassertion plus the full latency.

## Test plan
- Reset, then read HEX0, LED, KEYEV and CYCLE -> 0x7f, 0, 0 and a small count respectively. Write 0x12345678 to RAM 0x00000004, then read it back -> 0x12345678. The I/O write does not alter RAM.
- Write 0x3ff to 0xffffff80, then read LED -> led=10'h3ff. Write 0x40 to 0xffffff70 -> hex[41:35]=7'h40. Write to 0xffffff84, then read 0xffffff84 -> 0, with no output change.
- Hold key[1]=0 steady with DEB_CYCLES=16 -> KEY bit1=1 and KEYEV=0x2 exactly 18 edges later. Release the key -> KEY=0 and KEYEV stays 0x2. Write 0x2 to 0xffffff14 -> KEYEV=0.
- Toggle key[0] every 5 cycles for 100 cycles -> KEY and KEYEV bit0 stay 0. Hold key[0] low, then issue a W1C on the exact cycle of the flag set -> bit0 reads 1.
- Write CYCLE, then read it 10 cycles later -> 10. Force CYCLE to 0xffffffff via a long run or a backdoor -> the next cycle reads 0.
- Set sw=10'h155 and read SW -> 0x155 only from the 2nd edge after the change. Assert reset alongside a LED write of 0x3ff -> led=0.
